// File: rtl/vpi_sig_checker.sv
// Multi-channel sig/rfr compare engine with snapshot scan and
// free-running read-back counters.
module vpi_sig_checker #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int STOP_ON_FIRST = 0,
  parameter int IDX_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W         = $clog2(CHANNELS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      check,
  input  logic [CHANNELS-1:0]       mask,
  input  logic [CHANNELS*WIDTH-1:0] sig,
  input  logic [CHANNELS*WIDTH-1:0] rfr,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          mismatch_count,
  output logic [IDX_W-1:0]          first_bad,
  output logic                      first_bad_valid,
  output logic                      overrun,
  output logic [31:0]               count,
  output logic [31:0]               half_count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e                    state_q;
  logic                      check_q;
  logic [CHANNELS*WIDTH-1:0] snap_sig_q;
  logic [CHANNELS*WIDTH-1:0] snap_rfr_q;
  logic [CHANNELS-1:0]       snap_mask_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          fb_q, fb_d;
  logic                      found_q, found_d;
  logic                      done_q, pass_q, fbv_q, ovr_q;
  logic [CNT_W-1:0]          mc_q;
  logic [IDX_W-1:0]          fbo_q;
  logic [31:0]               count_q, half_q;

  logic                      req;
  logic [WIDTH-1:0]          cur_sig, cur_rfr;
  logic [CHANNELS-1:0]       mask_sh;
  logic                      mis, last, leave;

  assign req     = check & ~check_q;
  assign cur_sig = snap_sig_q[int'(idx_q)*WIDTH +: WIDTH];
  assign cur_rfr = snap_rfr_q[int'(idx_q)*WIDTH +: WIDTH];
  assign mask_sh = snap_mask_q >> idx_q;
  assign mis     = ~mask_sh[0] & (cur_sig != cur_rfr);
  assign last    = (idx_q == IDX_W'(CHANNELS - 1));
  assign leave   = last | ((STOP_ON_FIRST != 0) & mis);

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(mis);
    fb_d    = fb_q;
    found_d = found_q;
    if (mis && !found_q) begin
      fb_d    = idx_q;
      found_d = 1'b1;
    end
  end

  // Snapshot is pure datapath; the FSM decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      snap_sig_q  <= sig;
      snap_rfr_q  <= rfr;
      snap_mask_q <= mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      check_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fb_q    <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mc_q    <= '0;
      fbo_q   <= '0;
      fbv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      count_q <= '0;
      half_q  <= '0;
    end else begin
      check_q <= check;
      count_q <= count_q + 32'd2;
      if (count_q[1])
        half_q <= half_q + 32'd2;
      if (req && state_q != IDLE)
        ovr_q <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= SCAN;
            idx_q   <= '0;
            cnt_q   <= '0;
            fb_q    <= '0;
            found_q <= 1'b0;
          end
        end
        SCAN: begin
          cnt_q   <= cnt_d;
          fb_q    <= fb_d;
          found_q <= found_d;
          // Results land together with the done pulse.
          if (leave) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            mc_q    <= cnt_d;
            fbo_q   <= fb_d;
            fbv_q   <= found_d;
            pass_q  <= (cnt_d == '0);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch_count  = mc_q;
  assign first_bad       = fbo_q;
  assign first_bad_valid = fbv_q;
  assign overrun         = ovr_q;
  assign count           = count_q;
  assign half_count      = half_q;

endmodule
